// File: rtl/hfilter_5tap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hfilter_5tap_pkg
// Description : Shared widths, fill limit, default 1-4-6-4-1 coefficient set
//               and the pipeline side-band tag for the horizontal 5-tap FIR.
// Revision    : 1.0 - initial release
// ============================================================================
package hfilter_5tap_pkg;

  localparam int WIN_W    = 40;  // five packed pixels
  localparam int PIX_W    = 8;
  localparam int TAPS     = 5;
  localparam int COEF_W   = 8;
  localparam int PROD_W   = 17;  // 9-bit zero-extended pixel x 8-bit weight
  localparam int SUM_W    = 20;  // five products plus growth headroom
  localparam int FILL_MAX = 5;   // windows needed before output is meaningful
  localparam int FCNT_W   = 3;

  // Default binomial smoothing kernel, sum 16, normalised by >> 4.
  localparam logic signed [COEF_W-1:0] C0_DEF = 8'sd1;
  localparam logic signed [COEF_W-1:0] C1_DEF = 8'sd4;
  localparam logic signed [COEF_W-1:0] C2_DEF = 8'sd6;
  localparam logic signed [COEF_W-1:0] C3_DEF = 8'sd4;
  localparam logic signed [COEF_W-1:0] C4_DEF = 8'sd1;
  localparam int                       SHIFT_DEF = 4;

  // Side-band bits that travel with each window through the pipeline.
  typedef struct packed {
    logic valid;
    logic sol;
    logic byp;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/hfilter_5tap_round_clamp.sv
`default_nettype none
// ============================================================================
// Module      : round_clamp_u8
// Description : Normalises a signed filter sum: round-half-up by adding
//               2^(SHIFT-1), arithmetic shift right by SHIFT, then saturate
//               to the unsigned 8-bit pixel range. Purely combinational.
// Ports       : sum_in  - signed SUM_W-bit filter sum
//               pix_out - unsigned 8-bit clamped pixel
// Revision    : 1.0 - initial release
// ============================================================================
module round_clamp_u8
  import hfilter_5tap_pkg::*;
#(
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic signed [SUM_W-1:0] sum_in,
  output logic        [PIX_W-1:0] pix_out
);

  // One extra bit so the rounding offset can never wrap the sum.
  logic signed [SUM_W:0] widened;
  logic signed [SUM_W:0] rounded;
  logic signed [SUM_W:0] shifted;

  assign widened = (SUM_W+1)'(sum_in);

  if (SHIFT > 0) begin : g_round
    localparam logic signed [SUM_W:0] HALF = (SUM_W+1)'(1) << (SHIFT - 1);
    assign rounded = widened + HALF;
  end else begin : g_no_round
    assign rounded = widened;
  end

  assign shifted = rounded >>> SHIFT;

  always_comb begin
    pix_out = shifted[PIX_W-1:0];
    if (shifted[SUM_W]) begin
      pix_out = '0;
    end else if (|shifted[SUM_W-1:PIX_W]) begin
      pix_out = '1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hfilter_5tap.sv
`default_nettype none
// ============================================================================
// Module      : hfilter_5tap
// Description : Horizontal 5-tap FIR behind the pixel window shift register.
//               Three pipeline stages (multiply, sum, round/clamp); output is
//               suppressed until five pixels of the current line are in the
//               window. Fixed 3-clk latency, one pixel per clk, no stall.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               win_in         - p0=[7:0] oldest .. p4=[39:32] newest
//               win_valid      - win_in holds a freshly shifted window
//               h_sync         - single-cycle line-start pulse
//               bypass         - pass centre pixel p2 instead of filtering
//               pix_out        - filtered pixel (held while pix_valid=0)
//               pix_valid      - pix_out valid this cycle
//               pix_sol        - first valid pixel of the line
// Revision    : 1.0 - initial release
// ============================================================================
module hfilter_5tap
  import hfilter_5tap_pkg::*;
#(
  parameter logic signed [COEF_W-1:0] C0    = C0_DEF,
  parameter logic signed [COEF_W-1:0] C1    = C1_DEF,
  parameter logic signed [COEF_W-1:0] C2    = C2_DEF,
  parameter logic signed [COEF_W-1:0] C3    = C3_DEF,
  parameter logic signed [COEF_W-1:0] C4    = C4_DEF,
  parameter int                       SHIFT = SHIFT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIN_W-1:0] win_in,
  input  logic             win_valid,
  input  logic             h_sync,
  input  logic             bypass,
  output logic [PIX_W-1:0] pix_out,
  output logic             pix_valid,
  output logic             pix_sol
);

  localparam logic signed [COEF_W-1:0] COEF [TAPS] = '{C0, C1, C2, C3, C4};

  // ---------------------------------------------------------------- fill
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              accept;
  logic              first_win;

  always_comb begin
    fcnt_d = fcnt_q;
    if (h_sync) begin
      // A window arriving with h_sync already belongs to the new line.
      fcnt_d = win_valid ? FCNT_W'(1) : '0;
    end else if (win_valid && (fcnt_q != FCNT_W'(FILL_MAX))) begin
      fcnt_d = fcnt_q + 1'b1;
    end
  end

  assign accept    = win_valid && (fcnt_d == FCNT_W'(FILL_MAX));
  // Only the 4->5 transition can be accepted while fcnt_q is below 5.
  assign first_win = accept && (fcnt_q != FCNT_W'(FILL_MAX));

  // ------------------------------------------------------ S1: multiply
  logic signed [PROD_W-1:0] prod_d [TAPS];
  logic signed [PROD_W-1:0] prod_q [TAPS];
  logic        [PIX_W-1:0]  s1_p2_q, s1_p2_d;
  tag_t                     s1_tag_q, s1_tag_d;

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    logic signed [PIX_W:0] px;
    assign px        = $signed({1'b0, win_in[k*PIX_W +: PIX_W]});
    assign prod_d[k] = PROD_W'(px) * PROD_W'(COEF[k]);
  end

  always_comb begin
    s1_p2_d  = win_in[2*PIX_W +: PIX_W];
    s1_tag_d = '{valid: accept, sol: first_win, byp: bypass};
  end

  // ----------------------------------------------------------- S2: sum
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic        [PIX_W-1:0] s2_p2_q, s2_p2_d;
  tag_t                    s2_tag_q, s2_tag_d;

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum_d = sum_d + SUM_W'(prod_q[k]);
    end
    s2_p2_d  = s1_p2_q;
    s2_tag_d = s1_tag_q;
  end

  // -------------------------------------------------- S3: round/clamp
  logic [PIX_W-1:0] rc_pix;
  logic [PIX_W-1:0] pix_out_q, pix_out_d;
  logic             pix_valid_q, pix_valid_d;
  logic             pix_sol_q, pix_sol_d;

  round_clamp_u8 #(
    .SHIFT (SHIFT)
  ) u_round_clamp (
    .sum_in  (sum_q),
    .pix_out (rc_pix)
  );

  always_comb begin
    pix_out_d   = pix_out_q;
    pix_valid_d = s2_tag_q.valid;
    pix_sol_d   = s2_tag_q.valid && s2_tag_q.sol;
    if (s2_tag_q.valid) begin
      pix_out_d = s2_tag_q.byp ? s2_p2_q : rc_pix;
    end
  end

  // ----------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q      <= '0;
      s1_p2_q     <= '0;
      s1_tag_q    <= '0;
      sum_q       <= '0;
      s2_p2_q     <= '0;
      s2_tag_q    <= '0;
      pix_out_q   <= '0;
      pix_valid_q <= 1'b0;
      pix_sol_q   <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        prod_q[k] <= '0;
      end
    end else begin
      fcnt_q      <= fcnt_d;
      s1_p2_q     <= s1_p2_d;
      s1_tag_q    <= s1_tag_d;
      sum_q       <= sum_d;
      s2_p2_q     <= s2_p2_d;
      s2_tag_q    <= s2_tag_d;
      pix_out_q   <= pix_out_d;
      pix_valid_q <= pix_valid_d;
      pix_sol_q   <= pix_sol_d;
      for (int k = 0; k < TAPS; k++) begin
        prod_q[k] <= prod_d[k];
      end
    end
  end

  assign pix_out   = pix_out_q;
  assign pix_valid = pix_valid_q;
  assign pix_sol   = pix_sol_q;

endmodule
`default_nettype wire

// File: tb/tb_hfilter_5tap.sv
`default_nettype none
// ============================================================================
// Module      : tb_hfilter_5tap
// Description : Directed bench for hfilter_5tap. A per-cycle table of
//               {inputs, expected outputs} drives the default-kernel DUT;
//               a second DUT with kernel (0,-1,3,-1,0), SHIFT=0 covers the
//               clamp limits. Row expectations are sampled 1 time unit after
//               each clock edge, so a window in row r appears in row r+2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hfilter_5tap;

  logic        clk;
  logic        rst;
  logic [39:0] win;
  logic        win_valid;
  logic        h_sync;
  logic        bypass;
  logic [7:0]  pix_out,  c_pix_out;
  logic        pix_valid, c_pix_valid;
  logic        pix_sol,   c_pix_sol;

  int n_cmp;
  int n_bad;

  hfilter_5tap dut (
    .clk       (clk),
    .rst       (rst),
    .win_in    (win),
    .win_valid (win_valid),
    .h_sync    (h_sync),
    .bypass    (bypass),
    .pix_out   (pix_out),
    .pix_valid (pix_valid),
    .pix_sol   (pix_sol)
  );

  hfilter_5tap #(
    .C0    (8'sd0),
    .C1    (-8'sd1),
    .C2    (8'sd3),
    .C3    (-8'sd1),
    .C4    (8'sd0),
    .SHIFT (0)
  ) dut_c (
    .clk       (clk),
    .rst       (rst),
    .win_in    (win),
    .win_valid (win_valid),
    .h_sync    (h_sync),
    .bypass    (bypass),
    .pix_out   (c_pix_out),
    .pix_valid (c_pix_valid),
    .pix_sol   (c_pix_sol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix;   // pixel shifted into the window when wv=1
    logic       wv;
    logic       hs;
    logic       byp;
    logic       rs;
    logic       ev;    // expected pix_valid after this row's edge
    logic       es;    // expected pix_sol
    logic [7:0] ep;    // expected pix_out
  } vec_t;

  vec_t vecs[$];

  task automatic row(input int pix, input bit wv, input bit hs, input bit byp,
                     input bit rs, input bit ev, input bit es, input int ep);
    vec_t v;
    v.pix = 8'(pix); v.wv = wv; v.hs = hs; v.byp = byp; v.rs = rs;
    v.ev = ev; v.es = es; v.ep = 8'(ep);
    vecs.push_back(v);
  endtask

  task automatic idle(input int n, input int ep);
    for (int i = 0; i < n; i++) row(0, 0, 0, 0, 0, 0, 0, ep);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [39:0] cwin [7];
  int          cexp [7];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; win = '0; win_valid = 1'b0; h_sync = 1'b0; bypass = 1'b0;

    // ------------------------------------------------------ vector table
    // Constant 100 stream: windows 1-4 silent, window 5 tagged sol.
    row(0, 0, 1, 0, 0, 0, 0, 0);                          // r0
    for (int i = 0; i < 6; i++) row(100, 1, 0, 0, 0, 0, 0, 0); // r1-r6
    row(100, 1, 0, 0, 0, 1, 1, 100);                      // r7
    // New line while the old one drains; impulse 0,0,0,0,0,160,0,0,0,0,0.
    row(0,   0, 1, 0, 0, 1, 0, 100);                      // r8
    row(0,   1, 0, 0, 0, 1, 0, 100);                      // r9
    for (int i = 0; i < 4; i++) row(0, 1, 0, 0, 0, 0, 0, 100); // r10-r13
    row(160, 1, 0, 0, 0, 0, 0, 100);                      // r14
    row(0,   1, 0, 0, 0, 1, 1, 0);                        // r15
    row(0,   1, 0, 0, 0, 1, 0, 10);
    row(0,   1, 0, 0, 0, 1, 0, 40);
    row(0,   1, 0, 0, 0, 1, 0, 60);
    row(0,   1, 0, 0, 0, 1, 0, 40);                       // r19
    // Bypass line: ramp 10..50 then 200,0,0 with bypass toggling.
    row(0,   0, 1, 0, 0, 1, 0, 10);                       // r20
    row(10,  1, 0, 0, 0, 1, 0, 0);                        // r21
    row(20,  1, 0, 0, 0, 0, 0, 0);
    row(30,  1, 0, 0, 0, 0, 0, 0);
    row(40,  1, 0, 0, 0, 0, 0, 0);
    row(50,  1, 0, 1, 0, 0, 0, 0);                        // r25 bypass -> 30
    row(200, 1, 0, 1, 0, 0, 0, 0);                        // r26 bypass -> 40
    row(0,   1, 0, 0, 0, 1, 1, 30);                       // r27 filter -> 81
    row(0,   1, 0, 1, 0, 1, 0, 40);                       // r28 bypass -> 200
    // h_sync coincident with a window, then one window every 3rd clk.
    row(80,  1, 1, 0, 0, 1, 0, 81);                       // r29 window 1
    row(0,   0, 0, 0, 0, 1, 0, 200);                      // r30
    row(0,   0, 0, 0, 0, 0, 0, 200);                      // r31
    for (int w = 0; w < 3; w++) begin                     // r32-r40
      row(80, 1, 0, 0, 0, 0, 0, 200);
      idle(2, 200);
    end
    row(80,  1, 0, 0, 0, 0, 0, 200);                      // r41 window 5
    row(0,   0, 0, 0, 0, 0, 0, 200);
    row(0,   0, 0, 0, 0, 1, 1, 80);                       // r43
    row(80,  1, 0, 0, 0, 0, 0, 80);                       // r44 window 6
    idle(1, 80);
    row(0,   0, 0, 0, 0, 1, 0, 80);                       // r46
    idle(2, 80);                                          // r47-r48
    // Reset with three windows in flight.
    row(90,  1, 0, 0, 0, 0, 0, 80);                       // r49
    row(90,  1, 0, 0, 0, 0, 0, 80);                       // r50
    row(90,  1, 0, 0, 1, 0, 0, 0);                        // r51 rst
    idle(1, 0);                                           // r52
    row(0,   0, 1, 0, 0, 0, 0, 0);                        // r53 h_sync
    for (int i = 0; i < 4; i++) row(90, 1, 0, 0, 0, 0, 0, 0); // r54-r57
    idle(3, 0);                                           // r58-r60
    row(90,  1, 0, 0, 0, 0, 0, 0);                        // r61 window 5
    idle(1, 0);
    row(0,   0, 0, 0, 0, 1, 1, 90);                       // r63
    idle(1, 90);                                          // r64

    // --------------------------------------------------------- reset state
    step();
    step();
    chk("reset pix_out",   int'(pix_out),   0);
    chk("reset pix_valid", int'(pix_valid), 0);
    chk("reset pix_sol",   int'(pix_sol),   0);
    chk("reset clamp pix_valid", int'(c_pix_valid), 0);
    rst = 1'b0;

    // ----------------------------------------------------------- table run
    foreach (vecs[i]) begin
      rst       = vecs[i].rs;
      h_sync    = vecs[i].hs;
      win_valid = vecs[i].wv;
      bypass    = vecs[i].byp;
      if (vecs[i].wv) win = {vecs[i].pix, win[39:8]};
      step();
      chk($sformatf("row%0d pix_valid", i), int'(pix_valid), int'(vecs[i].ev));
      chk($sformatf("row%0d pix_sol",   i), int'(pix_sol),   int'(vecs[i].es));
      chk($sformatf("row%0d pix_out",   i), int'(pix_out),   int'(vecs[i].ep));
    end
    rst = 1'b0; h_sync = 1'b0; win_valid = 1'b0; bypass = 1'b0;

    // --------------------------------------------- clamp kernel sequence
    // Windows written {p4,p3,p2,p1,p0}; first four only fill the line.
    for (int i = 0; i < 4; i++) begin
      cwin[i] = '0;
      cexp[i] = 0;
    end
    cwin[4] = {8'd0,   8'd0,   8'd255, 8'd0,   8'd0};   // 765  -> 255
    cexp[4] = 255;
    cwin[5] = {8'd255, 8'd255, 8'd0,   8'd255, 8'd255}; // -510 -> 0
    cexp[5] = 0;
    cwin[6] = {8'd0,   8'd60,  8'd100, 8'd50,  8'd0};   // 190
    cexp[6] = 190;

    h_sync = 1'b1;
    step();
    h_sync = 1'b0;
    for (int i = 0; i < 10; i++) begin
      win_valid = (i < 7);
      if (i < 7) win = cwin[i];
      step();
      if (i >= 6 && i <= 8) begin
        chk($sformatf("clamp%0d pix_valid", i), int'(c_pix_valid), 1);
        chk($sformatf("clamp%0d pix_out",   i), int'(c_pix_out),   cexp[i-2]);
        chk($sformatf("clamp%0d pix_sol",   i), int'(c_pix_sol),   (i == 6) ? 1 : 0);
      end else begin
        chk($sformatf("clamp%0d pix_valid", i), int'(c_pix_valid), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
